// File: rtl/pwm_meter.sv
// PWM line meter: measures period and high time of an asynchronous PWM input and
// reports duty on the 10-bit generator scale, plus stuck-line and overrun flags.
module pwm_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [9:0]       duty,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] DIVIDE  = 2'd2;

    logic [1:0]       state;
    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             rise_det;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] snap_per;
    logic [CNT_W-1:0] snap_hi;
    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   rem_sub;
    logic             rem_ge;
    logic [9:0]       quo;
    logic [10:0]      quo_next;
    logic [3:0]       bit_cnt;
    logic             timeout_hit;

    assign rise_det    = sync2 & ~sync_prev;
    assign timeout_hit = (per_cnt == CNT_W'(TIMEOUT));
    assign rem_ge      = (rem >= {1'b0, snap_per});
    assign rem_sub     = rem - {1'b0, snap_per};
    assign quo_next    = {quo, rem_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= pwm_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // The restart value counts the rise cycle itself, so rises N apart snapshot exactly N.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise_det) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(sync2);
        end else begin
            if (per_cnt != '1)
                per_cnt <= per_cnt + 1'b1;
            if (sync2 && (hi_cnt != '1))
                hi_cnt <= hi_cnt + 1'b1;
        end
    end

    // high_time never exceeds period, so the remainder starts at high_time and the
    // first compare yields the 1024 bit directly; each later step shifts one bit in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            period    <= '0;
            high_time <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
            snap_per  <= '0;
            snap_hi   <= '0;
            rem       <= '0;
            quo       <= '0;
            bit_cnt   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_det) begin
                        stuck <= 1'b0;
                        state <= MEASURE;
                    end else if (timeout_hit && !stuck) begin
                        stuck <= 1'b1;
                        duty  <= sync2 ? 10'h3FF : 10'h000;
                        valid <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise_det) begin
                        snap_per <= per_cnt;
                        snap_hi  <= hi_cnt;
                        rem      <= {1'b0, hi_cnt};
                        quo      <= '0;
                        bit_cnt  <= '0;
                        state    <= DIVIDE;
                    end else if (timeout_hit) begin
                        stuck <= 1'b1;
                        duty  <= sync2 ? 10'h3FF : 10'h000;
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                DIVIDE: begin
                    if (rise_det)
                        overrun <= 1'b1;
                    rem     <= rem_ge ? (rem_sub << 1) : (rem << 1);
                    quo     <= quo_next[9:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'd10) begin
                        period    <= snap_per;
                        high_time <= snap_hi;
                        duty      <= quo_next[10] ? 10'h3FF : quo_next[9:0];
                        valid     <= 1'b1;
                        state     <= MEASURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
